// File: rtl/chain_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : chain_dump_collector
// Purpose  : Deserializes shadow-capture scan chains into tagged words and
//            arbitrates them round-robin onto one valid/ready stream.
// Option   : CHAIN_COLLECT_PARITY_EN builds the registered word_par output.
// Revision : 1.0  initial release
// ============================================================================
module chain_dump_collector #(
    parameter int CHAINS = 6,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [CHAINS-1:0] dump_en,
    input  logic [CHAINS-1:0] chains_in,
    input  logic [CHAINS-1:0] chains_in_vld,
    input  logic [CHAINS-1:0] chains_in_done,
    output logic [WORD_W-1:0] word_out,
    output logic [3:0]        word_chain,
    output logic [6:0]        word_bits,
    output logic              word_last,
    output logic              word_par,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic              busy,
    output logic              all_done,
    output logic [CHAINS-1:0] overflow
);
    localparam logic [6:0] FULL_CNT = 7'(WORD_W);

    logic [WORD_W-1:0] sh_q  [CHAINS];
    logic [WORD_W-1:0] sh_d  [CHAINS];
    logic [6:0]        cnt_q [CHAINS];
    logic [6:0]        cnt_d [CHAINS];
    logic [WORD_W-1:0] hd_q  [CHAINS];
    logic [WORD_W-1:0] hd_d  [CHAINS];
    logic [6:0]        hb_q  [CHAINS];
    logic [6:0]        hb_d  [CHAINS];
    logic [CHAINS-1:0] hf_q, hf_d, hl_q, hl_d;
    logic [CHAINS-1:0] flush_q, flush_d, fin_q, fin_d;
    logic [CHAINS-1:0] en_q, en_d, ovf_q, ovf_d;
    logic [3:0]        ptr_q, ptr_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              vld_q, vld_d, ol_q, ol_d;
    logic [WORD_W-1:0] od_q, od_d;
    logic [3:0]        oc_q, oc_d;
    logic [6:0]        ob_q, ob_d;

    logic              load_ok, gnt_vld, lo_vld, hi_vld, g_last;
    logic [3:0]        gnt_idx, lo_idx, hi_idx;
    logic [WORD_W-1:0] g_data;
    logic [6:0]        g_bits;

    // Round-robin: first full holding at or after the pointer, else wrap to the lowest.
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = 4'd0;
        hi_vld = 1'b0;
        hi_idx = 4'd0;
        for (int i = CHAINS - 1; i >= 0; i--) begin
            if (hf_q[i]) begin
                lo_vld = 1'b1;
                lo_idx = 4'(i);
            end
            if (hf_q[i] && (4'(i) >= ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = 4'(i);
            end
        end
    end

    assign load_ok = !vld_q || word_rdy;
    assign gnt_vld = load_ok && (hi_vld || lo_vld);
    assign gnt_idx = hi_vld ? hi_idx : lo_idx;

    always_comb begin
        g_data = '0;
        g_bits = 7'd0;
        g_last = 1'b0;
        for (int i = 0; i < CHAINS; i++) begin
            if (gnt_idx == 4'(i)) begin
                g_data = hd_q[i];
                g_bits = hb_q[i];
                g_last = hl_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHAINS; i++) begin
            sh_d[i]  = sh_q[i];
            cnt_d[i] = cnt_q[i];
            hd_d[i]  = hd_q[i];
            hb_d[i]  = hb_q[i];
        end
        hf_d    = hf_q;
        hl_d    = hl_q;
        flush_d = flush_q;
        fin_d   = fin_q;
        ovf_d   = ovf_q;
        en_d    = en_q & ~flush_q & ~fin_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        vld_d   = vld_q;
        od_d    = od_q;
        oc_d    = oc_q;
        ob_d    = ob_q;
        ol_d    = ol_q;

        if (load_ok) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                od_d  = g_data;
                oc_d  = gnt_idx;
                ob_d  = g_bits;
                ol_d  = g_last;
                ptr_d = (gnt_idx == 4'(CHAINS - 1)) ? 4'd0 : gnt_idx + 4'd1;
            end
        end

        for (int i = 0; i < CHAINS; i++) begin
            if (gnt_vld && (gnt_idx == 4'(i)))
                hf_d[i] = 1'b0;
            // A full shifter always moves before the terminator, so a done on
            // the last bit of a word still yields a separate empty last word.
            if (busy_q && !hf_d[i]) begin
                if (cnt_q[i] == FULL_CNT) begin
                    hf_d[i]  = 1'b1;
                    hd_d[i]  = sh_q[i];
                    hb_d[i]  = FULL_CNT;
                    hl_d[i]  = 1'b0;
                    sh_d[i]  = '0;
                    cnt_d[i] = 7'd0;
                end else if (flush_q[i]) begin
                    hf_d[i]    = 1'b1;
                    hd_d[i]    = sh_q[i];
                    hb_d[i]    = cnt_q[i];
                    hl_d[i]    = 1'b1;
                    sh_d[i]    = '0;
                    cnt_d[i]   = 7'd0;
                    flush_d[i] = 1'b0;
                    fin_d[i]   = 1'b1;
                end
            end
            if (en_q[i] && !flush_q[i] && !fin_q[i]) begin
                if (chains_in_vld[i]) begin
                    if (cnt_d[i] == FULL_CNT) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        for (int b = 0; b < WORD_W; b++) begin
                            if (cnt_d[i] == 7'(b))
                                sh_d[i][b] = chains_in[i];
                        end
                        cnt_d[i] = cnt_d[i] + 7'd1;
                    end
                end
                if (chains_in_done[i])
                    flush_d[i] = 1'b1;
            end
        end

        if (busy_q && (&fin_q) && !(|hf_q) && load_ok) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (!busy_q && start) begin
            busy_d  = 1'b1;
            done_d  = 1'b0;
            ovf_d   = '0;
            en_d    = '1;
            flush_d = '0;
            fin_d   = '0;
            hf_d    = '0;
            ptr_d   = 4'd0;
            vld_d   = 1'b0;
            for (int i = 0; i < CHAINS; i++) begin
                sh_d[i]  = '0;
                cnt_d[i] = 7'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAINS; i++) begin
                sh_q[i]  <= '0;
                cnt_q[i] <= 7'd0;
                hd_q[i]  <= '0;
                hb_q[i]  <= 7'd0;
            end
            hf_q    <= '0;
            hl_q    <= '0;
            flush_q <= '0;
            fin_q   <= '0;
            en_q    <= '0;
            ovf_q   <= '0;
            ptr_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            od_q    <= '0;
            oc_q    <= 4'd0;
            ob_q    <= 7'd0;
            ol_q    <= 1'b0;
        end else begin
            for (int i = 0; i < CHAINS; i++) begin
                sh_q[i]  <= sh_d[i];
                cnt_q[i] <= cnt_d[i];
                hd_q[i]  <= hd_d[i];
                hb_q[i]  <= hb_d[i];
            end
            hf_q    <= hf_d;
            hl_q    <= hl_d;
            flush_q <= flush_d;
            fin_q   <= fin_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            od_q    <= od_d;
            oc_q    <= oc_d;
            ob_q    <= ob_d;
            ol_q    <= ol_d;
        end
    end

`ifdef CHAIN_COLLECT_PARITY_EN
    logic par_q;

    // Bits above the valid count are always zero, so a full-width XOR suffices.
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (gnt_vld)
            par_q <= ^g_data;
    end

    assign word_par = par_q;
`else
    assign word_par = 1'b0;
`endif

    assign dump_en    = en_q;
    assign word_out   = od_q;
    assign word_chain = oc_q;
    assign word_bits  = ob_q;
    assign word_last  = ol_q;
    assign word_vld   = vld_q;
    assign busy       = busy_q;
    assign all_done   = done_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_chain_dump_collector
// Purpose  : Scoreboard bench for chain_dump_collector with a word-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_chain_dump_collector;
    localparam int CH = 6;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CH-1:0] dump_en;
    logic [CH-1:0] chains_in;
    logic [CH-1:0] chains_in_vld;
    logic [CH-1:0] chains_in_done;
    logic [W-1:0]  word_out;
    logic [3:0]    word_chain;
    logic [6:0]    word_bits;
    logic          word_last;
    logic          word_par;
    logic          word_vld;
    logic          word_rdy;
    logic          busy;
    logic          all_done;
    logic [CH-1:0] overflow;

    always #5 clk = ~clk;

    chain_dump_collector #(.CHAINS(CH), .WORD_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dump_en(dump_en),
        .chains_in(chains_in), .chains_in_vld(chains_in_vld),
        .chains_in_done(chains_in_done), .word_out(word_out),
        .word_chain(word_chain), .word_bits(word_bits), .word_last(word_last),
        .word_par(word_par), .word_vld(word_vld), .word_rdy(word_rdy),
        .busy(busy), .all_done(all_done), .overflow(overflow)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [6:0]   b;
        logic         l;
    } exp_t;

    exp_t         sbq [CH][$];
    int           order_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] macc [CH];
    int           mn [CH];
    logic [255:0] stream [CH];
    int           len [CH];
    bit           send_done [CH];
    bit           wild [CH];
    int           sent [CH];
    bit           fin [CH];
    int           last_cnt [CH];
    int           words_seen;
    int           stall_left;
    bit           rdy_rand;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    function automatic logic exp_par(input logic [W-1:0] d);
`ifdef CHAIN_COLLECT_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    // Word model: bits fill LSB-first, each WORD_W bits form a word, done closes
    // the chain with whatever remains (possibly nothing) as the last word.
    task automatic model_bit(input int c, input logic b);
        exp_t e;
        macc[c] = macc[c] | (32'(b) << mn[c]);
        mn[c]++;
        if (mn[c] == W) begin
            e.d = macc[c]; e.b = 7'(W); e.l = 1'b0;
            sbq[c].push_back(e);
            macc[c] = '0;
            mn[c] = 0;
        end
    endtask

    task automatic model_done(input int c);
        exp_t e;
        e.d = macc[c]; e.b = 7'(mn[c]); e.l = 1'b1;
        sbq[c].push_back(e);
        macc[c] = '0;
        mn[c] = 0;
    endtask

    task automatic drive_rdy();
        if (stall_left > 0) begin
            word_rdy = 1'b0;
            stall_left--;
        end else if (rdy_rand) begin
            word_rdy = ($urandom_range(3) != 0);
        end else begin
            word_rdy = 1'b1;
        end
    endtask

    task automatic step_idle();
        @(posedge clk); #1;
        drive_rdy();
        start = 1'b0;
        chains_in = '0;
        chains_in_vld = '0;
        chains_in_done = '0;
    endtask

    task automatic do_start();
        for (int c = 0; c < CH; c++) begin
            sbq[c].delete();
            macc[c] = '0; mn[c] = 0; sent[c] = 0; fin[c] = 1'b0; last_cnt[c] = 0;
        end
        words_seen = 0;
        step_idle();
        start = 1'b1;
        step_idle();
        @(negedge clk);
        chk("start_dump_en", 64'(dump_en), 64'h3f);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_clears_all_done", 64'(all_done), 64'd0);
    endtask

    task automatic run_streams(input int density, input bit noise, input bit garbage);
        int cyc = 0;
        bit active = 1'b1;
        while (active && cyc < 3000) begin
            logic [CH-1:0] v, b, d;
            @(posedge clk); #1;
            drive_rdy();
            v = '0; b = '0; d = '0;
            active = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (!fin[c]) begin
                    if (sent[c] < len[c] && (density >= 100 || int'($urandom_range(99)) < density)) begin
                        v[c] = 1'b1;
                        b[c] = stream[c][sent[c][7:0]];
                        if (!wild[c]) model_bit(c, b[c]);
                        sent[c]++;
                    end
                    if (sent[c] == len[c]) begin
                        fin[c] = 1'b1;
                        if (send_done[c]) begin
                            d[c] = 1'b1;
                            if (!wild[c]) model_done(c);
                        end
                    end else begin
                        active = 1'b1;
                    end
                end else if (garbage) begin
                    v[c] = 1'($urandom_range(1));
                    b[c] = 1'($urandom_range(1));
                    d[c] = 1'($urandom_range(1));
                end
            end
            chains_in = b;
            chains_in_vld = v;
            chains_in_done = d;
            start = noise && ($urandom_range(15) == 0);
            cyc++;
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin
            step_idle();
            @(negedge clk);
            n++;
        end while (!all_done && n < bound);
        chk("all_done_reached", 64'(all_done), 64'd1);
    endtask

    task automatic end_checks(input logic [CH-1:0] exp_ovf);
        int rem = 0;
        int badlast = 0;
        for (int c = 0; c < CH; c++) begin
            rem += sbq[c].size();
            if (last_cnt[c] != 1) badlast++;
        end
        chk("busy_low_at_end", 64'(busy), 64'd0);
        chk("dump_en_low_at_end", 64'(dump_en), 64'd0);
        chk("words_not_delivered", 64'(rem), 64'd0);
        chk("chains_without_one_last", 64'(badlast), 64'd0);
        chk("overflow_flags", 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic check_reset_vals();
        chk("rst_dump_en", 64'(dump_en), 64'd0);
        chk("rst_word_vld", 64'(word_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_word_out", 64'(word_out), 64'd0);
        chk("rst_word_chain", 64'(word_chain), 64'd0);
        chk("rst_word_bits", 64'(word_bits), 64'd0);
        chk("rst_word_last", 64'(word_last), 64'd0);
        chk("rst_word_par", 64'(word_par), 64'd0);
    endtask

    task automatic test_short_chain();
        for (int c = 0; c < CH; c++) begin
            len[c] = 0; send_done[c] = 1'b1; wild[c] = 1'b0;
        end
        stream[2] = 256'(40'hEF_1EADBEEF);
        len[2] = 40;
        do_start();
        run_streams(100, 1'b0, 1'b0);
        wait_done(500);
        chk("words_total_short", 64'(words_seen), 64'd7);
        end_checks('0);
    endtask

    // Monitor: every accepted word is popped from its chain's queue and compared.
    initial begin
        logic         pv = 1'b0;
        logic         pr = 1'b0;
        logic [45:0]  pf = '0;
        exp_t         e;
        int           ci;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr)
                    chk("held_while_stalled",
                        64'({word_vld, word_out, word_chain, word_bits, word_last, word_par}),
                        64'({1'b1, pf[44:0]}));
                if (word_vld && word_rdy) begin
                    ci = int'(word_chain);
                    words_seen++;
                    if (order_q.size() > 0)
                        chk("rr_order", 64'(word_chain), 64'(order_q.pop_front()));
                    if (ci >= CH) begin
                        chk("chain_index_range", 64'(word_chain), 64'(CH - 1));
                    end else begin
                        if (word_last) last_cnt[ci]++;
                        if (!wild[ci]) begin
                            if (sbq[ci].size() == 0) begin
                                n_total++;
                                $display("FAIL unexpected_word: chain %0d data %0h, expected none", ci, word_out);
                            end else begin
                                e = sbq[ci].pop_front();
                                chk("word_data_bits_last", 64'({word_out, word_bits, word_last}),
                                    64'({e.d, e.b, e.l}));
                                chk("word_parity", 64'(word_par), 64'(exp_par(e.d)));
                            end
                        end
                    end
                end
                pv = word_vld;
                pr = word_rdy;
                pf = {1'b1, word_out, word_chain, word_bits, word_last, word_par};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        rst = 1'b1; start = 1'b0; word_rdy = 1'b0;
        chains_in = '0; chains_in_vld = '0; chains_in_done = '0;
        stall_left = 0; rdy_rand = 1'b0; words_seen = 0;
        for (int c = 0; c < CH; c++) begin
            wild[c] = 1'b0; len[c] = 0; send_done[c] = 1'b1; last_cnt[c] = 0;
            macc[c] = '0; mn[c] = 0; sent[c] = 0; fin[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // Six chains, 64 bits each, done on the last bit, strict round-robin order.
        for (int c = 0; c < CH; c++) begin
            stream[c] = 256'(64'hDEADBEEF_DEADBEEF);
            len[c] = 64;
        end
        do_start();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < CH; c++) order_q.push_back(c);
        run_streams(100, 1'b0, 1'b0);
        wait_done(500);
        chk("words_total_full", 64'(words_seen), 64'd18);
        chk("rr_order_all_seen", 64'(order_q.size()), 64'd0);
        order_q.delete();
        end_checks('0);
        repeat (5) step_idle();
        @(negedge clk);
        chk("all_done_held", 64'(all_done), 64'd1);

        test_short_chain();

        // 50-cycle stall from the start of the dump: nothing may be lost.
        for (int c = 0; c < CH; c++) begin
            stream[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            len[c] = 40 + int'($urandom_range(80));
        end
        stall_left = 52;
        do_start();
        run_streams(100, 1'b0, 1'b0);
        wait_done(2000);
        end_checks('0);

        // Long stall: chain 3 streams 130 bits into it and must flag overflow.
        for (int c = 0; c < CH; c++) begin
            stream[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            len[c] = 0;
        end
        len[1] = 64;
        len[3] = 130;
        wild[3] = 1'b1;
        stall_left = 162;
        do_start();
        run_streams(100, 1'b0, 1'b0);
        wait_done(2000);
        end_checks(6'b001000);
        wild[3] = 1'b0;

        // Random lengths/densities, random ready, stray start pulses, post-done noise.
        rdy_rand = 1'b1;
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < CH; c++) begin
                stream[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                len[c] = int'($urandom_range(150));
            end
            do_start();
            run_streams(30 + int'($urandom_range(70)), 1'b1, 1'b1);
            wait_done(3000);
            end_checks('0);
        end
        rdy_rand = 1'b0;

        // Reset in the middle of a dump with words in flight.
        for (int c = 0; c < CH; c++) begin
            stream[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            len[c] = 40;
            send_done[c] = 1'b0;
        end
        stall_left = 1000;
        do_start();
        run_streams(100, 1'b0, 1'b0);
        @(negedge clk);
        chk("word_in_flight_before_rst", 64'(word_vld), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < CH; c++) sbq[c].delete();
        stall_left = 0;
        @(negedge clk);
        check_reset_vals();
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            drive_rdy();
            chains_in = CH'($urandom);
            chains_in_vld = CH'($urandom);
            chains_in_done = CH'($urandom);
            @(negedge clk);
            if (word_vld || busy || (dump_en != '0)) vcnt++;
        end
        chk("quiet_after_rst", 64'(vcnt), 64'd0);
        for (int c = 0; c < CH; c++) send_done[c] = 1'b1;

        test_short_chain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chain_dump_collector.md
# chain_dump_collector

Downstream consumer of the shadow-capture scan chains. Drives the per-chain dump enables and deserializes each chain's serial bit stream (bit, valid, done) into WORD_W-bit words. It arbitrates the words round-robin onto a single valid/ready word stream tagged with chain ID, last-word flag and valid-bit count. It feeds the host readout path and reports completion once every chain has finished and drained.

## Interface
Parameters:
- CHAINS, 6, number of serial chains consumed (1..16)
- WORD_W, 32, deserialized word width (8..64)

Ports:
- clk  in  1  sole clock; same clock the capture block uses for its dump clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a dump; ignored while busy=1
- dump_en  out  CHAINS  per-chain dump enable to the capture block
- chains_in  in  CHAINS  serial data bit per chain
- chains_in_vld  in  CHAINS  chains_in[i] is valid this cycle
- chains_in_done  in  CHAINS  chain i has shifted out its final bit; sampled only while dump_en[i]=1
- word_out  out  WORD_W  deserialized word; first-received bit in bit 0
- word_chain  out  4  source chain index
- word_bits  out  7  number of valid bits in word_out, 0..WORD_W
- word_last  out  1  final word of chain word_chain
- word_par  out  1  even parity over word_out (see Configuration)
- word_vld  out  1  word stream valid
- word_rdy  in  1  word stream ready
- busy  out  1  dump in progress
- all_done  out  1  every chain is done and all words are accepted; held until the next start or rst
- overflow  out  CHAINS  sticky per-chain bit-loss flag

## Operation
- IDLE: on a start pulse, set dump_en to all ones and busy=1, clear all_done and overflow, clear all shifters and counters.
- Per chain i, a shift register and a bit counter 0..WORD_W. On vld[i], write the bit at position count and increment count.
- When count reaches WORD_W, move the word into a 1-deep holding register (bits=WORD_W, last=0) and reset count to 0. Entry to holding is delayed one cycle by a full shift+count? No: the move happens the cycle after the WORD_W-th bit.
- Holding full and shifter full, with a further vld bit: drop the bit and set overflow[i]. The shifter stalls until holding frees.
- done[i] (a vld bit in the same cycle is counted first):
  - Flush the shifter as the last word, with word_bits=count (0 if count=0, which gives an empty terminator word) and word_last=1.
  - dump_en[i] drops on the next edge. Later vld/done on chain i are ignored.
- Arbiter: round-robin over holding-full chains. The pointer starts after the last-granted chain; it starts at 0 after start.
- A grant loads the output register when the output is empty or accepted this cycle.
- word_out, word_chain, word_bits, word_last and word_par are held stable while word_vld=1 and word_rdy=0.
- Completion: all chains done, all holdings empty, and the final word accepted. Then busy drops and all_done is set on the same edge.

## Timing
- Reset values:
  - dump_en=0, word_vld=0, busy=0, all_done=0, overflow=0.
  - word_out=0, word_chain=0, word_bits=0, word_last=0, word_par=0.
- rst mid-dump: all state is cleared at the next edge. Words in flight are discarded and no word_last is emitted.
- Latency, uncontested with word_rdy=1: WORD_W-th bit at edge t gives holding at t+1 and word_vld at t+2.
- Latency for done at t: the last word is valid at t+2 and dump_en[i]=0 at t+1.
- Throughput: one word per cycle. Each chain sustains one bit per cycle indefinitely if word_rdy is high at least 1 cycle in CHAINS×WORD_W/… (any share ≥ its word rate).
- Simultaneous events:
  - A full holding plus a same-cycle grant frees the holding. A shifter completing that same cycle may refill it on the next edge without overflow.
  - A start pulse coinciding with the completion edge is ignored.

## Configuration
- CHAIN_COLLECT_PARITY_EN defined: word_par = XOR of word_out bits [word_bits-1:0], registered with the word.
- Not defined: word_par is constant 0 and no parity logic is built.

## Test plan
- 6 chains, each sending 64 bits of 0xDEADBEEF_DEADBEEF then done, word_rdy=1:
  - required: 18 words total, 3 per chain.
  - per chain: two words of 0xDEADBEEF with bits=32, then one word with bits=0 and last=1.
  - chain order round-robin 0..5; then all_done=1 and dump_en=0.
- Chain 2 sends 40 bits 0x1EADBEEF then 0xEF, with done on the 40th bit:
  - required: word 0x1EADBEEF (bits=32), then word 0x000000EF (bits=8, last=1).
  - with parity enabled, word_par=1 on the 0xEF word.
- word_rdy low 50 cycles mid-dump:
  - word_vld stays high and the data is stable; no word is lost or duplicated.
  - overflow is set only on chains that streamed more than 2×WORD_W bits during the stall.
- Chain 4 asserts done with no bits: a single word with bits=0 and last=1 is emitted.
- rst asserted mid-dump: the next cycle shows all outputs at their reset values, and no further word_vld appears until a new start.
- start pulsed while busy: no effect on dump_en, counters or word order.
